// File: rtl/core_pkg.sv
// core_pkg: shared pipeline types for the in-order core.
// Provides the ID/EX/MEM pipeline bus and the hazard controller state enum.
package core;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } hazard_state_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       is_load;
        logic       is_mem;
        logic       uses_rs1;
        logic       uses_rs2;
    } pipeline_bus_t;

endpackage

// File: rtl/hazard_ctrl_detect.sv
// hazard_detect: combinational hazard terms from the ID, EX and MEM buses.
// Ports: id_bus_i/ex_bus_i/mem_bus_i - stage buses; branch_taken_i - EX branch taken;
//        dmem_ready_i - data memory done; load_use_o, mem_wait_o, br_o - hazard terms.
module hazard_detect
    import core::*;
(
    input  pipeline_bus_t id_bus_i,
    input  pipeline_bus_t ex_bus_i,
    input  pipeline_bus_t mem_bus_i,
    input  logic          branch_taken_i,
    input  logic          dmem_ready_i,
    output logic          load_use_o,
    output logic          mem_wait_o,
    output logic          br_o
);

    // Only a subset of each bus matters here; fold the rest away.
    logic unused_ok;
    assign unused_ok = ^{id_bus_i, ex_bus_i, mem_bus_i};

    assign load_use_o = ex_bus_i.valid & ex_bus_i.is_load & (ex_bus_i.rd != 5'd0) & id_bus_i.valid &
                        ((id_bus_i.uses_rs1 & (id_bus_i.rs1 == ex_bus_i.rd)) |
                         (id_bus_i.uses_rs2 & (id_bus_i.rs2 == ex_bus_i.rd)));
    assign mem_wait_o = mem_bus_i.valid & mem_bus_i.is_mem & ~dmem_ready_i;
    assign br_o       = branch_taken_i & ex_bus_i.valid;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall, memory-wait freeze and branch-flush controller.
// Ports: clk, rst (async, active-high); id/ex/mem_bus_i - stage buses; branch_taken_i;
//        dmem_ready_i; stall_fe_o, bubble_o, freeze_o, flush_o - Mealy controls;
//        state_o - FSM state; stall_cycles_o - saturating stall count; mem_timeout_o - sticky.
module hazard_ctrl
    import core::*;
#(
    parameter int LU_CYCLES   = 1,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  pipeline_bus_t        id_bus_i,
    input  pipeline_bus_t        ex_bus_i,
    input  pipeline_bus_t        mem_bus_i,
    input  logic                 branch_taken_i,
    input  logic                 dmem_ready_i,
    output logic                 stall_fe_o,
    output logic                 bubble_o,
    output logic                 freeze_o,
    output logic                 flush_o,
    output hazard_state_t        state_o,
    output logic [CNT_W-1:0]     stall_cycles_o,
    output logic                 mem_timeout_o
);

    localparam int TW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TW-1:0] TO_MAX = TW'(MEM_TIMEOUT);
    localparam logic [2:0] LU_INIT = 3'(LU_CYCLES - 1);

    hazard_state_t state_q, state_d, eff;
    logic [2:0] lu_cnt_q, lu_cnt_d;
    logic ret_lu_q, ret_lu_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [CNT_W-1:0] cnt_q;
    logic to_q;
    logic load_use, mem_wait, br;
    logic stall, bubble, freeze, flush;

    hazard_detect u_detect (
        .id_bus_i       (id_bus_i),
        .ex_bus_i       (ex_bus_i),
        .mem_bus_i      (mem_bus_i),
        .branch_taken_i (branch_taken_i),
        .dmem_ready_i   (dmem_ready_i),
        .load_use_o     (load_use),
        .mem_wait_o     (mem_wait),
        .br_o           (br)
    );

    always_comb begin
        // On the MEM_WAIT exit cycle, behave as the state being returned to.
        eff = (state_q == MEM_WAIT) ? ((ret_lu_q && lu_cnt_q != 3'd0) ? LU_STALL : RUN) : state_q;
        state_d  = eff;
        lu_cnt_d = lu_cnt_q;
        ret_lu_d = ret_lu_q;
        to_cnt_d = to_cnt_q;
        stall    = 1'b0;
        bubble   = 1'b0;
        freeze   = 1'b0;
        flush    = 1'b0;
        if (mem_wait) begin
            freeze   = 1'b1;
            state_d  = MEM_WAIT;
            ret_lu_d = (state_q == MEM_WAIT) ? ret_lu_q : (state_q == LU_STALL);
            to_cnt_d = (state_q != MEM_WAIT) ? TW'(1) : (to_cnt_q == TO_MAX) ? to_cnt_q : to_cnt_q + 1'b1;
        end else if (eff == LU_STALL) begin
            stall    = 1'b1;
            bubble   = 1'b1;
            lu_cnt_d = lu_cnt_q - 3'd1;
            state_d  = (lu_cnt_q == 3'd1) ? RUN : LU_STALL;
        end else if (br) begin
            flush = 1'b1;
        end else if (load_use && state_q != MEM_WAIT) begin
            stall  = 1'b1;
            bubble = 1'b1;
            if (LU_CYCLES > 1) begin
                state_d  = LU_STALL;
                lu_cnt_d = LU_INIT;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= RUN;
            lu_cnt_q <= 3'd0;
            ret_lu_q <= 1'b0;
            to_cnt_q <= '0;
            cnt_q    <= '0;
            to_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            lu_cnt_q <= lu_cnt_d;
            ret_lu_q <= ret_lu_d;
            to_cnt_q <= to_cnt_d;
            if ((stall || freeze) && !(&cnt_q))
                cnt_q <= cnt_q + 1'b1;
            // A wait longer than MEM_TIMEOUT cycles trips the sticky flag.
            if (state_q == MEM_WAIT && mem_wait && to_cnt_q == TO_MAX)
                to_q <= 1'b1;
        end
    end

    assign stall_fe_o     = stall & ~rst;
    assign bubble_o       = bubble & ~rst;
    assign freeze_o       = freeze & ~rst;
    assign flush_o        = flush & ~rst;
    assign state_o        = state_q;
    assign stall_cycles_o = cnt_q;
    assign mem_timeout_o  = to_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: three hazard_ctrl configurations under shared directed and random stimulus.
module tb_hazard_ctrl;
    import core::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipeline_bus_t id_b, ex_b, mem_b;
    logic br_in, rdy;
    logic stall[3], bubble[3], freeze[3], flush[3], tmo[3];
    hazard_state_t st[3];
    logic [31:0] cnt0, cnt1;
    logic [3:0] cnt2;

    hazard_ctrl #(.LU_CYCLES(1), .MEM_TIMEOUT(255), .CNT_W(32)) u0 (
        .clk(clk), .rst(rst), .id_bus_i(id_b), .ex_bus_i(ex_b), .mem_bus_i(mem_b),
        .branch_taken_i(br_in), .dmem_ready_i(rdy), .stall_fe_o(stall[0]), .bubble_o(bubble[0]),
        .freeze_o(freeze[0]), .flush_o(flush[0]), .state_o(st[0]), .stall_cycles_o(cnt0),
        .mem_timeout_o(tmo[0]));
    hazard_ctrl #(.LU_CYCLES(3), .MEM_TIMEOUT(3), .CNT_W(32)) u1 (
        .clk(clk), .rst(rst), .id_bus_i(id_b), .ex_bus_i(ex_b), .mem_bus_i(mem_b),
        .branch_taken_i(br_in), .dmem_ready_i(rdy), .stall_fe_o(stall[1]), .bubble_o(bubble[1]),
        .freeze_o(freeze[1]), .flush_o(flush[1]), .state_o(st[1]), .stall_cycles_o(cnt1),
        .mem_timeout_o(tmo[1]));
    hazard_ctrl #(.LU_CYCLES(7), .MEM_TIMEOUT(255), .CNT_W(4)) u2 (
        .clk(clk), .rst(rst), .id_bus_i(id_b), .ex_bus_i(ex_b), .mem_bus_i(mem_b),
        .branch_taken_i(br_in), .dmem_ready_i(rdy), .stall_fe_o(stall[2]), .bubble_o(bubble[2]),
        .freeze_o(freeze[2]), .flush_o(flush[2]), .state_o(st[2]), .stall_cycles_o(cnt2),
        .mem_timeout_o(tmo[2]));

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s (cycle %0d): got %0d, want %0d", nm, cyc, act, exp);
        end
    endtask

    // Reference model: pending stall cycles per load-use, a stall is due whenever
    // any are pending and memory is not blocking; every mem_wait cycle freezes.
    int nlu[3] = '{1, 3, 7};
    int tlim[3] = '{255, 3, 255};
    longint cmax[3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 15};
    int pend[3];
    bit pmw[3];
    int run[3];
    bit mto[3];
    longint mcnt[3];

    always @(negedge clk) begin
        logic mw, lu, b, e_stl;
        logic e_fl;
        hazard_state_t e_st;
        logic [63:0] acnt;
        mw = mem_b.valid & mem_b.is_mem & ~rdy;
        lu = ex_b.valid & ex_b.is_load & (ex_b.rd != 5'd0) & id_b.valid &
             ((id_b.uses_rs1 && id_b.rs1 == ex_b.rd) || (id_b.uses_rs2 && id_b.rs2 == ex_b.rd));
        b = br_in & ex_b.valid;
        for (int i = 0; i < 3; i++) begin
            acnt = (i == 0) ? 64'(cnt0) : (i == 1) ? 64'(cnt1) : 64'(cnt2);
            if (rst) begin
                pend[i] = 0; pmw[i] = 0; run[i] = 0; mto[i] = 0; mcnt[i] = 0;
                e_st = RUN; e_stl = 0; e_fl = 0;
            end else begin
                e_st = pmw[i] ? MEM_WAIT : (pend[i] > 0) ? LU_STALL : RUN;
                e_stl = 0;
                e_fl = 0;
                if (!mw) begin
                    if (pend[i] > 0) begin
                        e_stl = 1; pend[i]--;
                    end else if (b) begin
                        e_fl = 1;
                    end else if (lu && !pmw[i]) begin
                        e_stl = 1; pend[i] = nlu[i] - 1;
                    end
                end
            end
            chk($sformatf("u%0d state", i), 64'(st[i]), 64'(e_st));
            chk($sformatf("u%0d stall_cycles", i), acnt, 64'(mcnt[i]));
            chk($sformatf("u%0d mem_timeout", i), 64'(tmo[i]), 64'(mto[i]));
            chk($sformatf("u%0d stall_fe", i), 64'(stall[i]), 64'(e_stl));
            chk($sformatf("u%0d bubble", i), 64'(bubble[i]), 64'(e_stl));
            chk($sformatf("u%0d freeze", i), 64'(freeze[i]), 64'(mw & ~rst));
            chk($sformatf("u%0d flush", i), 64'(flush[i]), 64'(e_fl));
            if (!rst) begin
                if ((e_stl || mw) && mcnt[i] < cmax[i]) mcnt[i]++;
                run[i] = mw ? run[i] + 1 : 0;
                if (run[i] > tlim[i]) mto[i] = 1;
                pmw[i] = mw;
            end
        end
        cyc++;
    end

    function automatic pipeline_bus_t ld(input logic [4:0] rd);
        pipeline_bus_t r = '0;
        r.valid = 1; r.is_load = 1; r.is_mem = 1; r.rd = rd;
        return r;
    endfunction

    function automatic pipeline_bus_t op(input logic [4:0] r1, input logic [4:0] r2, input logic u1, input logic u2);
        pipeline_bus_t r = '0;
        r.valid = 1; r.rs1 = r1; r.rs2 = r2; r.uses_rs1 = u1; r.uses_rs2 = u2;
        return r;
    endfunction

    function automatic pipeline_bus_t sw();
        pipeline_bus_t r = '0;
        r.valid = 1; r.is_mem = 1;
        return r;
    endfunction

    task automatic drive(input pipeline_bus_t i_, input pipeline_bus_t e_, input pipeline_bus_t m_,
                         input logic b_, input logic r_);
        id_b = i_; ex_b = e_; mem_b = m_; br_in = b_; rdy = r_;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int burst;
        pipeline_bus_t rb;
        drive('0, '0, '0, 0, 1);
        rst = 1;
        repeat (2) tick();
        rst = 0;
        repeat (3) tick();
        // Load-use: lw x5 in EX, add x6,x5,x1 in ID.
        drive(op(5, 1, 1, 0), ld(5), '0, 0, 1);
        @(negedge clk);
        chk("A1 u0 stall", 64'(stall[0]), 1);
        chk("A1 u0 bubble", 64'(bubble[0]), 1);
        chk("A1 u1 state", 64'(st[1]), 64'(RUN));
        tick();
        drive('0, '0, '0, 0, 1);
        @(negedge clk);
        chk("A2 u0 stall", 64'(stall[0]), 0);
        chk("A2 u0 cnt", 64'(cnt0), 1);
        chk("A2 u1 stall", 64'(stall[1]), 1);
        chk("A2 u1 state", 64'(st[1]), 64'(LU_STALL));
        tick();
        @(negedge clk);
        chk("A3 u1 stall", 64'(stall[1]), 1);
        chk("A3 u1 state", 64'(st[1]), 64'(LU_STALL));
        tick();
        @(negedge clk);
        chk("A4 u1 stall", 64'(stall[1]), 0);
        chk("A4 u1 state", 64'(st[1]), 64'(RUN));
        chk("A4 u1 cnt", 64'(cnt1), 3);
        repeat (6) tick();
        @(negedge clk);
        chk("A u2 cnt", 64'(cnt2), 7);
        tick();
        // Memory wait of 5 cycles.
        drive('0, '0, sw(), 0, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("B freeze", 64'(freeze[0]), 1);
            tick();
        end
        drive('0, '0, '0, 0, 1);
        @(negedge clk);
        chk("B exit freeze", 64'(freeze[0]), 0);
        chk("B exit state", 64'(st[0]), 64'(MEM_WAIT));
        chk("B u0 timeout", 64'(tmo[0]), 0);
        chk("B u1 timeout", 64'(tmo[1]), 1);
        repeat (3) tick();
        @(negedge clk);
        chk("B u1 timeout sticky", 64'(tmo[1]), 1);
        tick();
        // Memory wait arriving during a multi-cycle load-use stall.
        drive(op(5, 1, 1, 0), ld(5), '0, 0, 1);
        @(negedge clk);
        chk("C1 u1 stall", 64'(stall[1]), 1);
        tick();
        drive('0, '0, sw(), 0, 0);
        @(negedge clk);
        chk("C2 u1 freeze", 64'(freeze[1]), 1);
        chk("C2 u1 stall", 64'(stall[1]), 0);
        tick();
        @(negedge clk);
        chk("C3 u1 freeze", 64'(freeze[1]), 1);
        tick();
        drive('0, '0, '0, 0, 1);
        @(negedge clk);
        chk("C4 u1 stall", 64'(stall[1]), 1);
        chk("C4 u1 freeze", 64'(freeze[1]), 0);
        chk("C4 u1 state", 64'(st[1]), 64'(MEM_WAIT));
        chk("C4 u0 stall", 64'(stall[0]), 0);
        tick();
        @(negedge clk);
        chk("C5 u1 stall", 64'(stall[1]), 1);
        chk("C5 u1 state", 64'(st[1]), 64'(LU_STALL));
        tick();
        @(negedge clk);
        chk("C6 u1 stall", 64'(stall[1]), 0);
        chk("C6 u1 state", 64'(st[1]), 64'(RUN));
        repeat (6) tick();
        @(negedge clk);
        chk("C u0 cnt", 64'(cnt0), 9);
        chk("C u1 cnt", 64'(cnt1), 13);
        chk("C u2 cnt saturated", 64'(cnt2), 15);
        tick();
        // Branch taken together with a load-use.
        drive(op(5, 1, 1, 0), ld(5), '0, 1, 1);
        @(negedge clk);
        chk("D u0 flush", 64'(flush[0]), 1);
        chk("D u0 stall", 64'(stall[0]), 0);
        chk("D u0 bubble", 64'(bubble[0]), 0);
        chk("D u1 flush", 64'(flush[1]), 1);
        tick();
        // Load to x0 never stalls.
        drive(op(0, 0, 1, 1), ld(0), '0, 0, 1);
        @(negedge clk);
        chk("E u0 stall", 64'(stall[0]), 0);
        chk("E u1 stall", 64'(stall[1]), 0);
        tick();
        // Reset in the middle of a memory wait.
        drive('0, '0, sw(), 0, 0);
        repeat (2) tick();
        rst = 1;
        @(negedge clk);
        chk("F u0 freeze", 64'(freeze[0]), 0);
        chk("F u0 state", 64'(st[0]), 64'(RUN));
        chk("F u1 timeout", 64'(tmo[1]), 0);
        chk("F u2 cnt", 64'(cnt2), 0);
        tick();
        rst = 0;
        drive('0, '0, '0, 0, 1);
        repeat (2) tick();
        // Random traffic with small register indices and bursty memory stalls.
        burst = 0;
        for (int n = 0; n < 3000; n++) begin
            rb = '0;
            rb.valid = ($urandom_range(0, 3) != 0);
            rb.rs1 = 5'($urandom_range(0, 3));
            rb.rs2 = 5'($urandom_range(0, 3));
            rb.uses_rs1 = 1'($urandom_range(0, 1));
            rb.uses_rs2 = 1'($urandom_range(0, 1));
            id_b = rb;
            rb = '0;
            rb.valid = ($urandom_range(0, 3) != 0);
            rb.rd = 5'($urandom_range(0, 3));
            rb.is_load = 1'($urandom_range(0, 1));
            ex_b = rb;
            rb = '0;
            rb.valid = ($urandom_range(0, 4) != 0);
            rb.is_mem = ($urandom_range(0, 4) != 0);
            mem_b = rb;
            br_in = ($urandom_range(0, 5) == 0);
            if (burst > 0) begin
                rdy = 0;
                burst--;
            end else begin
                rdy = 1;
                if ($urandom_range(0, 7) == 0) burst = $urandom_range(0, 6);
            end
            rst = ($urandom_range(0, 499) == 0);
            tick();
        end
        rst = 0;
        drive('0, '0, '0, 0, 1);
        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
